// File: rtl/vector_load_gather_if.sv
// Memory read channel between the gather engine (master) and data memory (slave).
// There is one request in flight at a time: req/addr are held until gnt, and the data comes back on rvalid.
interface vector_load_gather_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/vector_load_gather.sv
// Strided vector load: fetches up to LANES elements one at a time and commits them as a single register write.
// Optional feature macro: VLG_BOUNDS_CHECK_EN (rejects destination registers above 2 with an err pulse).
module vector_load_gather #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int LANES = 8,
  parameter int VAW   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AW-1:0]          base_addr,
  input  logic [AW-1:0]          stride,
  input  logic [31:0]            vlen,
  input  logic [VAW-1:0]         vdst,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  vector_load_gather_if.master   mem,
  output logic                   vreg_write,
  output logic [VAW-1:0]         vreg_addr,
  output logic [LANES*DW-1:0]    wdata_v
);

  localparam int LW = $clog2(LANES);
  localparam int IW = LW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

  state_t          state_r;
  state_t          state_s;
  logic [AW-1:0]   addr_r;
  logic [AW-1:0]   stride_r;
  logic [VAW-1:0]  vdst_r;
  logic [IW-1:0]   n_r;
  logic [IW-1:0]   idx_r;
  logic [DW-1:0]   lane_r [LANES];
  logic            done_zero_r;
  logic            err_r;

  logic            accept_s;
  logic            zero_s;
  logic            bad_s;
  logic            capture_s;
  logic            bad_vdst_s;
  logic [IW-1:0]   n_s;

`ifdef VLG_BOUNDS_CHECK_EN
  assign bad_vdst_s = (vdst > VAW'(2));
`else
  assign bad_vdst_s = 1'b0;
`endif

  assign n_s = (vlen > 32'(LANES)) ? IW'(LANES) : IW'(vlen);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    zero_s    = 1'b0;
    bad_s     = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (bad_vdst_s) begin
            bad_s = 1'b1;
          end else if (vlen == 32'd0) begin
            zero_s = 1'b1;
          end else begin
            accept_s = 1'b1;
            state_s  = REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          capture_s = 1'b1;
          if ((idx_r + IW'(1)) == n_r) begin
            state_s = WRITE;
          end else begin
            state_s = REQ;
          end
        end else begin
          state_s = WAIT;
        end
      end
      WRITE:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand latches, element capture and running address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r      <= {AW{1'b0}};
      stride_r    <= {AW{1'b0}};
      vdst_r      <= {VAW{1'b0}};
      n_r         <= {IW{1'b0}};
      idx_r       <= {IW{1'b0}};
      done_zero_r <= 1'b0;
      err_r       <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= {DW{1'b0}};
      end
    end else begin
      done_zero_r <= zero_s;
      err_r       <= bad_s;
      if (accept_s) begin
        addr_r   <= base_addr;
        stride_r <= stride;
        vdst_r   <= vdst;
        n_r      <= n_s;
        idx_r    <= {IW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
          lane_r[i] <= {DW{1'b0}};
        end
      end else if (capture_s) begin
        lane_r[idx_r[LW-1:0]] <= mem.mem_rdata;
        idx_r                 <= idx_r + IW'(1);
        // Adding the stride each step gives base + idx*stride, wrapping modulo 2^AW.
        addr_r                <= addr_r + stride_r;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign wdata_v[DW*g +: DW] = lane_r[g];
  end

  assign busy         = (state_r != IDLE);
  assign mem.mem_req  = (state_r == REQ);
  assign mem.mem_addr = addr_r;
  assign vreg_write   = (state_r == WRITE);
  assign vreg_addr    = vdst_r;
  assign done         = (state_r == WRITE) | done_zero_r;
  assign err          = err_r;

endmodule

// File: tb/tb_vector_load_gather.sv
// Randomized scoreboard bench for vector_load_gather with a stalling memory responder.
// Honours VLG_BOUNDS_CHECK_EN when it is defined for the build.
module tb_vector_load_gather;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [31:0]  stride;
  logic [31:0]  vlen;
  logic [4:0]   vdst;
  logic         busy, done, err, vreg_write;
  logic [4:0]   vreg_addr;
  logic [255:0] wdata_v;

  vector_load_gather_if #(.AW(32), .DW(32)) mif ();

  vector_load_gather dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .vlen(vlen), .vdst(vdst), .busy(busy), .done(done), .err(err), .mem(mif),
    .vreg_write(vreg_write), .vreg_addr(vreg_addr), .wdata_v(wdata_v)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    int           kind;   // 0 vector write, 1 empty-load done, 2 err
    logic [4:0]   va;
    logic [255:0] vec;
    int unsigned  t0;
    bit           lat;
    int           n;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  int g_lo = 0, g_hi = 0, r_lo = 0, r_hi = 0;
  bit stray = 1'b0;
  bit ident = 1'b1;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return ident ? a : ((a ^ 32'hC3A5_0F1E) + 32'h0000_1357);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drives one start pulse and records what the load must produce.
  task automatic issue(input logic [31:0] b, input logic [31:0] s, input logic [31:0] l,
                       input logic [4:0] d);
    exp_t        e;
    int          n;
    bit          bad;
    logic [31:0] a;
    @(negedge clk);
    start = 1'b1; base_addr = b; stride = s; vlen = l; vdst = d;
    n = (l > 32'd8) ? 8 : int'(l);
`ifdef VLG_BOUNDS_CHECK_EN
    bad = (d > 5'd2);
`else
    bad = 1'b0;
`endif
    e.t0 = cyc; e.va = d; e.vec = '0; e.n = n;
    if (bad) e.kind = 2;
    else if (n == 0) e.kind = 1;
    else begin
      e.kind = 0;
      for (int i = 0; i < n; i++) begin
        a = b + s * 32'(i);
        addr_q.push_back(a);
        e.vec[32*i +: 32] = memval(a);
      end
    end
    e.lat = (e.kind != 0) || (g_hi == 0 && r_hi == 0);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0 || busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk_cnt++;
    if (t < 2000) pass_cnt++;
    else $display("FAIL %s timeout: %0d outputs and %0d requests outstanding",
                  name, exp_q.size(), addr_q.size());
  endtask

  // Memory responder: random grant stall, random read latency, optional stray rvalid while requesting.
  int          phase, cnt;
  logic [31:0] cur;
  initial begin
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
    phase = 0; cnt = 0; cur = 32'h0;
    forever begin
      @(negedge clk);
      mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = $urandom;
      if (rst) phase = 0;
      else if (phase == 0) begin
        if (mif.mem_req) begin
          cur = mif.mem_addr;
          if (addr_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_req: addr %0h while no request expected", cur);
          end else check("req_addr", cur, addr_q.pop_front());
          cnt = $urandom_range(g_hi, g_lo);
          if (cnt == 0) begin
            mif.mem_gnt = 1'b1; cnt = $urandom_range(r_hi, r_lo); phase = 2;
          end else begin
            phase = 1;
            if (stray) mif.mem_rvalid = 1'b1;
          end
        end
      end else if (phase == 1) begin
        check("req_held", mif.mem_req, 1'b1);
        check("addr_held", mif.mem_addr, cur);
        cnt--;
        if (cnt == 0) begin
          mif.mem_gnt = 1'b1; cnt = $urandom_range(r_hi, r_lo); phase = 2;
        end else if (stray) mif.mem_rvalid = 1'b1;
      end else begin
        if (cnt == 0) begin
          mif.mem_rvalid = 1'b1; mif.mem_rdata = memval(cur); phase = 0;
        end else cnt--;
      end
    end
  end

  // Output monitor: every write/done/err pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (vreg_write || done || err)) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_output: write=%0b done=%0b err=%0b with nothing expected",
                   vreg_write, done, err);
        end else begin
          e = exp_q.pop_front();
          check("vreg_write", vreg_write, e.kind == 0);
          check("done", done, e.kind != 2);
          check("err", err, e.kind == 2);
          if (e.kind == 0) begin
            check("vreg_addr", vreg_addr, e.va);
            check("wdata_v", wdata_v, e.vec);
          end
          if (e.lat) check("latency", cyc - e.t0, (e.kind == 0) ? 2 * e.n + 1 : 1);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 32'h0; stride = 32'h0; vlen = 32'h0; vdst = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem_req", mif.mem_req, 1'b0);
    check("rst_mem_addr", mif.mem_addr, 32'h0);
    check("rst_vreg_write", vreg_write, 1'b0);
    check("rst_vreg_addr", vreg_addr, 5'd0);
    check("rst_wdata", wdata_v, 256'h0);
    rst = 1'b0;

    issue(32'h100, 32'd4, 32'd8, 5'd1);      drain("full_load");
    issue(32'h40, 32'h10, 32'd3, 5'd2);      drain("short_load");
    issue(32'h200, 32'd4, 32'd0, 5'd1);      drain("empty_load");
    issue(32'h300, 32'd4, 32'd20, 5'd0);     drain("clamped_load");

    g_lo = 5; g_hi = 5; r_lo = 2; r_hi = 2; stray = 1'b1;
    issue(32'h1000, 32'd8, 32'd4, 5'd2);
    repeat (3) @(negedge clk);
    start = 1'b1; base_addr = 32'hDEAD_0000; vlen = 32'd2; vdst = 5'd0;
    @(negedge clk);
    start = 1'b0;
    drain("stalled_load");

    g_lo = 0; g_hi = 0; r_lo = 0; r_hi = 0; stray = 1'b0;
    issue(32'h2000, 32'd4, 32'd8, 5'd1);
    repeat (8) @(negedge clk);
    check("abort_req_before", mif.mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_req_async", mif.mem_req, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_lanes", wdata_v, 256'h0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(32'h3000, 32'd4, 32'd5, 5'd0);     drain("after_abort");

    issue(32'h4000, 32'd4, 32'd4, 5'd3);     drain("vdst3");

    ident = 1'b0;
    for (int k = 0; k < 24; k++) begin
      g_hi = $urandom_range(3, 0);
      r_hi = $urandom_range(3, 0);
      stray = 1'($urandom_range(1, 0));
      issue($urandom, ($urandom_range(3, 0) == 0) ? $urandom : 32'($urandom_range(64, 0)),
            ($urandom_range(7, 0) == 0) ? $urandom : 32'($urandom_range(12, 0)),
            5'($urandom_range(7, 0)));
      drain("random_load");
    end

    check("queues_empty", exp_q.size() + addr_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
